// File: rtl/taylor_term_gen.sv
// taylor_term_gen: sequential generator of Taylor-series terms x^k/k! for an
// unsigned Q0.W input x (0 <= x < 1), with exp, sin and cos term sequences.
// Each new term is formed from the previous one by one or two sub-steps of
// T <- floor(trunc(T*x)/d). A sub-step is one multiply cycle followed by a
// W-cycle restoring divide.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin an operation (sampled only in IDLE)
//   mode            00 exp, 01 sin, 10 cos, 11 exp
//   Xbus            x in Q0.W, latched on the accepted start
//   Tbus            current term magnitude (Q0.W)
//   term_k          power/factorial index of Tbus
//   term_neg        term sign (1 = subtract)
//   term_valid      Tbus/term_k/term_neg valid
//   term_ready      consumer accepts the term when term_valid & term_ready
//   busy            high from the accepted start until Done
//   Done            one-cycle pulse after the last term is accepted
//   Sbus            (TAYLOR_ACCUM_EN only) signed running sum of +/-Tbus
//
// Optional feature macro: TAYLOR_ACCUM_EN adds the Sbus running-sum output.
module taylor_term_gen #(
  parameter int unsigned W       = 16,
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned KW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  Xbus,
  output logic [W-1:0]  Tbus,
  output logic [KW-1:0] term_k,
  output logic          term_neg,
  output logic          term_valid,
  input  logic          term_ready,
`ifdef TAYLOR_ACCUM_EN
  output logic signed [W+1:0] Sbus,
`endif
  output logic          busy,
  output logic          Done
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned DW = KW + 1;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned EW = $clog2(N_TERMS + 1);
  localparam logic [1:0] MODE_SIN = 2'b01;
  localparam logic [1:0] MODE_COS = 2'b10;

  typedef enum logic [2:0] {IDLE, MUL, DIV, EMIT, FIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  t_q, t_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    steps_q, steps_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic [W-1:0]  tbus_d;
  logic [KW-1:0] term_k_d;
  logic          term_neg_d, term_valid_d, busy_d, done_d;

  logic [W-1:0]  prod_hi;
  logic [DW:0]   rem_ext;
  logic          sub_ok;
  logic [DW-1:0] rem_sh;
  logic [W-1:0]  quo_sh;
  logic          is_trig, is_trig_d;

`ifdef TAYLOR_ACCUM_EN
  localparam int unsigned SW = W + 2;
  logic [SW-1:0] sum_d;
`endif

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    mode_d     = mode_q;
    t_d        = t_q;
    k_d        = k_q;
    div_d      = div_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    steps_d    = steps_q;
    ecnt_d     = ecnt_q;
    prod_hi    = '0;
    rem_ext    = '0;
    sub_ok     = 1'b0;
    rem_sh     = '0;
    quo_sh     = '0;
    tbus_d     = '0;
    term_k_d   = '0;
    term_neg_d = 1'b0;
`ifdef TAYLOR_ACCUM_EN
    sum_d      = Sbus;
`endif
    is_trig    = (mode_q == MODE_SIN) || (mode_q == MODE_COS);

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d    = Xbus;
          mode_d = mode;
          t_d    = Xbus;
          k_d    = KW'(1);
          ecnt_d = '0;
`ifdef TAYLOR_ACCUM_EN
          sum_d  = '0;
`endif
          // cos starts at k=2, so it needs one sub-step before the first term
          if (mode == MODE_COS) begin
            steps_d = 2'd1;
            state_d = MUL;
          end else begin
            state_d = EMIT;
          end
        end
      end
      MUL: begin
        // Truncated Q0.W product: keep the upper W bits
        prod_hi = W'((PW'(t_q) * PW'(x_q)) >> W);
        quo_d   = prod_hi;
        rem_d   = '0;
        cnt_d   = '0;
        div_d   = DW'(k_q) + DW'(1);
        state_d = DIV;
      end
      DIV: begin
        // One restoring-division step; the quotient shifts in where the dividend shifts out
        rem_ext = {rem_q, quo_q[W-1]};
        sub_ok  = (rem_ext >= {1'b0, div_q});
        rem_sh  = sub_ok ? DW'(rem_ext - {1'b0, div_q}) : rem_ext[DW-1:0];
        quo_sh  = {quo_q[W-2:0], sub_ok};
        rem_d   = rem_sh;
        quo_d   = quo_sh;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          t_d     = quo_sh;
          k_d     = k_q + KW'(1);
          steps_d = steps_q - 2'd1;
          state_d = (steps_q == 2'd1) ? EMIT : MUL;
        end
      end
      EMIT: begin
        if (term_ready) begin
          ecnt_d = ecnt_q + EW'(1);
`ifdef TAYLOR_ACCUM_EN
          sum_d  = term_neg ? (Sbus - SW'(Tbus)) : (Sbus + SW'(Tbus));
`endif
          if (ecnt_q == EW'(N_TERMS - 1)) begin
            state_d = FIN;
          end else begin
            steps_d = is_trig ? 2'd2 : 2'd1;
            state_d = MUL;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    is_trig_d    = (mode_d == MODE_SIN) || (mode_d == MODE_COS);
    term_valid_d = (state_d == EMIT);
    if (term_valid_d) begin
      tbus_d     = t_d;
      term_k_d   = k_d;
      term_neg_d = is_trig_d & k_d[1];
    end
    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      mode_q     <= '0;
      t_q        <= '0;
      k_q        <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      steps_q    <= '0;
      ecnt_q     <= '0;
      Tbus       <= '0;
      term_k     <= '0;
      term_neg   <= 1'b0;
      term_valid <= 1'b0;
      busy       <= 1'b0;
      Done       <= 1'b0;
`ifdef TAYLOR_ACCUM_EN
      Sbus       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      mode_q     <= mode_d;
      t_q        <= t_d;
      k_q        <= k_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      steps_q    <= steps_d;
      ecnt_q     <= ecnt_d;
      Tbus       <= tbus_d;
      term_k     <= term_k_d;
      term_neg   <= term_neg_d;
      term_valid <= term_valid_d;
      busy       <= busy_d;
      Done       <= done_d;
`ifdef TAYLOR_ACCUM_EN
      Sbus       <= sum_d;
`endif
    end
  end

endmodule
